// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-aware round-robin arbiter sharing one AXI-Stream output between two sources
module axis_packet_arbiter #(
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] AXIS_IN1_TDATA,
    input  logic                  AXIS_IN1_TVALID,
    input  logic                  AXIS_IN1_TLAST,
    output logic                  AXIS_IN1_TREADY,
    input  logic [DATA_WIDTH-1:0] AXIS_IN2_TDATA,
    input  logic                  AXIS_IN2_TVALID,
    input  logic                  AXIS_IN2_TLAST,
    output logic                  AXIS_IN2_TREADY,
    output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                  AXIS_OUT_TVALID,
    output logic                  AXIS_OUT_TLAST,
    input  logic                  AXIS_OUT_TREADY,
    output logic [CNT_WIDTH-1:0]  PKT_COUNT1,
    output logic [CNT_WIDTH-1:0]  PKT_COUNT2
);
    typedef enum logic [1:0] {IDLE, BUSY1, BUSY2} state_t;

    state_t state, state_nxt;
    logic   last2, last2_nxt;
    logic   busy1, busy2, eop1, eop2;

    assign busy1 = state == BUSY1;
    assign busy2 = state == BUSY2;
    assign eop1  = busy1 & AXIS_IN1_TVALID & AXIS_OUT_TREADY & AXIS_IN1_TLAST;
    assign eop2  = busy2 & AXIS_IN2_TVALID & AXIS_OUT_TREADY & AXIS_IN2_TLAST;

    // grant state and round-robin history; last2 set means source 2 was served most recently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last2 <= 1'b1;
        end else begin
            state <= state_nxt;
            last2 <= last2_nxt;
        end
    end

    // grant only moves on a TLAST handshake, so packets never interleave
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = AXIS_IN1_TVALID & (~AXIS_IN2_TVALID | last2) ? BUSY1 :
                                 AXIS_IN2_TVALID ? BUSY2 : IDLE;
            BUSY1:   if (eop1) state_nxt = AXIS_IN2_TVALID ? BUSY2 : AXIS_IN1_TVALID ? BUSY1 : IDLE;
            BUSY2:   if (eop2) state_nxt = AXIS_IN1_TVALID ? BUSY1 : AXIS_IN2_TVALID ? BUSY2 : IDLE;
            default: state_nxt = IDLE;
        endcase
        last2_nxt = state_nxt == BUSY2 ? 1'b1 : state_nxt == BUSY1 ? 1'b0 : last2;
    end

    // zero-latency output mux; ready back to a source depends only on grant and downstream ready
    always_comb begin
        AXIS_OUT_TDATA  = busy1 ? AXIS_IN1_TDATA  : busy2 ? AXIS_IN2_TDATA  : '0;
        AXIS_OUT_TVALID = busy1 ? AXIS_IN1_TVALID : busy2 ? AXIS_IN2_TVALID : 1'b0;
        AXIS_OUT_TLAST  = busy1 ? AXIS_IN1_TLAST  : busy2 ? AXIS_IN2_TLAST  : 1'b0;
        AXIS_IN1_TREADY = busy1 & AXIS_OUT_TREADY;
        AXIS_IN2_TREADY = busy2 & AXIS_OUT_TREADY;
    end

    // per-source forwarded-packet counters, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PKT_COUNT1 <= '0;
            PKT_COUNT2 <= '0;
        end else begin
            if (eop1) PKT_COUNT1 <= PKT_COUNT1 + 1'b1;
            if (eop2) PKT_COUNT2 <= PKT_COUNT2 + 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: randomized and directed bench with a packet-level reference model
module tb_axis_packet_arbiter;
    localparam int DW = 256;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data  [1:2];
    logic          in_valid [1:2];
    logic          in_last  [1:2];
    logic          in_ready [1:2];
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, out_tready;
    logic [CW-1:0] cnt1, cnt2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int gen_seq [1:2];
    int exp_seq [1:2];
    int m_own = 0;
    int m_last = 2;
    logic [CW-1:0] m_cnt [1:2];
    int out_cyc [$];
    int pkt_src [$];

    axis_packet_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(rst),
        .AXIS_IN1_TDATA(in_data[1]), .AXIS_IN1_TVALID(in_valid[1]),
        .AXIS_IN1_TLAST(in_last[1]), .AXIS_IN1_TREADY(in_ready[1]),
        .AXIS_IN2_TDATA(in_data[2]), .AXIS_IN2_TVALID(in_valid[2]),
        .AXIS_IN2_TLAST(in_last[2]), .AXIS_IN2_TREADY(in_ready[2]),
        .AXIS_OUT_TDATA(out_data), .AXIS_OUT_TVALID(out_valid),
        .AXIS_OUT_TLAST(out_last), .AXIS_OUT_TREADY(out_tready),
        .PKT_COUNT1(cnt1), .PKT_COUNT2(cnt2)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // beat payload: random filler with source id and per-source sequence number in the low bits
    function automatic logic [DW-1:0] mk(input int s, input int q);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        d[39:0] = {8'(s), 32'(q)};
        return d;
    endfunction

    // downstream ready: 0 always on, 1 toggling, 2 random with 75% duty
    initial begin
        out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~out_tready : ($urandom_range(0, 3) != 0);
        end
    end

    // reference model: who owns the output, what must appear, and which beat comes next per source
    always @(negedge clk) begin
        logic [DW-1:0] e_data;
        logic [3:0]    e_ctl;
        int            o;
        cyc++;
        if (rst) begin
            m_own = 0;
            m_last = 2;
            m_cnt[1] = '0;
            m_cnt[2] = '0;
            exp_seq[1] = gen_seq[1];
            exp_seq[2] = gen_seq[2];
        end
        e_data = '0;
        e_ctl = '0;
        if (m_own == 1) begin
            e_data = in_data[1];
            e_ctl = {in_valid[1], in_last[1], out_tready, 1'b0};
        end else if (m_own == 2) begin
            e_data = in_data[2];
            e_ctl = {in_valid[2], in_last[2], 1'b0, out_tready};
        end
        chk("out_tdata", out_data, e_data);
        chk("valid_last_rdy1_rdy2", {out_valid, out_last, in_ready[1], in_ready[2]}, e_ctl);
        chk("pkt_count1", cnt1, m_cnt[1]);
        chk("pkt_count2", cnt2, m_cnt[2]);
        if (!rst) begin
            if (m_own == 0) begin
                if (in_valid[1] && (!in_valid[2] || m_last == 2)) m_own = 1;
                else if (in_valid[2]) m_own = 2;
            end else if (in_valid[m_own] && out_tready) begin
                chk("beat_order", out_data[39:0], {8'(m_own), 32'(exp_seq[m_own])});
                exp_seq[m_own]++;
                out_cyc.push_back(cyc);
                if (in_last[m_own]) begin
                    m_cnt[m_own]++;
                    pkt_src.push_back(m_own);
                    o = 3 - m_own;
                    if (in_valid[o]) m_own = o;
                    else if (!in_valid[m_own]) m_own = 0;
                end
            end
            if (m_own != 0) m_last = m_own;
        end
    end

    // drive one packet; gap percentage inserts idle cycles only between beats of the packet
    task automatic send(input int s, input int len, input int gap);
        for (int b = 0; b < len; b++) begin
            bit hs;
            int t;
            if (b > 0 && $urandom_range(0, 99) < gap) begin
                in_valid[s] = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_data[s] = mk(s, gen_seq[s]);
            in_last[s] = b == len - 1;
            in_valid[s] = 1'b1;
            hs = 1'b0;
            t = 0;
            while (!hs) begin
                @(negedge clk);
                if (rst) begin
                    in_valid[s] = 1'b0;
                    return;
                end
                hs = in_ready[s];
                @(posedge clk);
                #1;
                if (!hs && ++t > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake_timeout src%0d: got no handshake, expected one within 2000 cycles", s);
                    in_valid[s] = 1'b0;
                    return;
                end
            end
            gen_seq[s]++;
        end
        in_valid[s] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_cyc.delete();
        pkt_src.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int t;
        for (int s = 1; s <= 2; s++) begin
            in_valid[s] = 1'b0;
            in_last[s] = 1'b0;
            in_data[s] = '0;
            gen_seq[s] = 0;
            exp_seq[s] = 0;
            m_cnt[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        start = cyc;
        send(1, 3, 0);
        chk("t1_beats", out_cyc.size(), 3);
        chk("t1_first_beat_cycle", out_cyc[0], start + 2);
        chk("t1_back_to_back", out_cyc[2] - out_cyc[0], 2);
        chk("t1_count1", cnt1, 1);
        chk("t1_count2", cnt2, 0);

        do_reset();
        fork
            send(1, 2, 0);
            send(2, 2, 0);
        join
        chk("t2_first_pkt_src", pkt_src[0], 1);
        chk("t2_second_pkt_src", pkt_src[1], 2);
        chk("t2_no_bubble", out_cyc[3] - out_cyc[0], 3);

        do_reset();
        fork
            repeat (4) send(1, $urandom_range(1, 4), 0);
            repeat (4) send(2, $urandom_range(1, 4), 0);
        join
        chk("t3_pkts", pkt_src.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_pkt%0d_src", i), pkt_src[i], (i % 2) + 1);
        chk("t3_count1", cnt1, 4);
        chk("t3_count2", cnt2, 4);

        do_reset();
        rdy_mode = 1;
        fork
            send(2, 4, 100);
            begin
                repeat (2) @(posedge clk);
                #1;
                send(1, 3, 0);
            end
        join
        rdy_mode = 0;
        chk("t4_beats", out_cyc.size(), 7);
        chk("t4_first_pkt_src", pkt_src[0], 2);
        chk("t4_second_pkt_src", pkt_src[1], 1);

        do_reset();
        fork
            send(1, 4, 0);
            begin
                t = 0;
                while (out_cyc.size() < 1 && t < 100) begin
                    @(posedge clk);
                    t++;
                end
                #2 chk("t5_pre_reset_tvalid", out_valid, 1);
                #1 rst = 1'b1;
                #1;
                chk("t5_async_tvalid", out_valid, 0);
                chk("t5_async_tlast", out_last, 0);
                chk("t5_async_tdata", out_data, 0);
                chk("t5_async_tready1", in_ready[1], 0);
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        out_cyc.delete();
        pkt_src.delete();
        send(2, 2, 0);
        chk("t5_pkts", pkt_src.size(), 1);
        chk("t5_pkt_src", pkt_src[0], 2);
        chk("t5_count1", cnt1, 0);
        chk("t5_count2", cnt2, 1);

        do_reset();
        repeat (17) send(1, 1, 0);
        chk("t6_wrap_count1", cnt1, 1);
        chk("t6_count2", cnt2, 0);

        do_reset();
        rdy_mode = 2;
        fork
            repeat (25) send(1, $urandom_range(1, 5), 30);
            repeat (25) send(2, $urandom_range(1, 5), 30);
        join
        rdy_mode = 0;
        chk("t7_pkts", pkt_src.size(), 50);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-aware round-robin arbiter that shares one AXI-Stream output between two AXI-Stream input sources. An input holds the output from the first beat of a packet through its TLAST beat, so packets are never interleaved. Sits in front of the downstream packet consumer wherever two producers feed a single stream. Per-input forwarded-packet counters are provided for status readback.

## Interface
- DATA_WIDTH, 256, width of every TDATA bus
- CNT_WIDTH, 32, width of each packet counter
- clk  input  1  clock; all logic rising-edge
- reset  input  1  asynchronous, active-high reset
- AXIS_IN1_TDATA  input  DATA_WIDTH  source 1 data
- AXIS_IN1_TVALID  input  1  source 1 valid
- AXIS_IN1_TLAST  input  1  source 1 end-of-packet
- AXIS_IN1_TREADY  output  1  source 1 ready
- AXIS_IN2_TDATA / TVALID / TLAST / TREADY  same as source 1, for source 2
- AXIS_OUT_TDATA  output  DATA_WIDTH  arbitrated data
- AXIS_OUT_TVALID  output  1  arbitrated valid
- AXIS_OUT_TLAST  output  1  arbitrated end-of-packet
- AXIS_OUT_TREADY  input  1  downstream ready
- PKT_COUNT1  output  CNT_WIDTH  packets forwarded from source 1
- PKT_COUNT2  output  CNT_WIDTH  packets forwarded from source 2

## Operation
- Handshake: a beat transfers when TVALID and TREADY are both high at a rising clk edge.
- State machine: IDLE, BUSY1, BUSY2. A register last_served (1 or 2) records the most recently granted source.
- IDLE: all TREADY outputs 0; AXIS_OUT_TVALID = 0; AXIS_OUT_TDATA and AXIS_OUT_TLAST = 0.
  - Only IN1 valid: go to BUSY1. Only IN2 valid: go to BUSY2.
  - Both valid: grant the source that is not last_served.
  - Neither valid: stay in IDLE.
- BUSYx: AXIS_OUT_TDATA/TVALID/TLAST = INx TDATA/TVALID/TLAST; AXIS_INx_TREADY = AXIS_OUT_TREADY; the other source's TREADY = 0.
  - last_served <= x on entry.
- Leaving BUSYx happens only on a handshake with AXIS_OUT_TLAST = 1. On that edge:
  - other source TVALID = 1: go to BUSYother.
  - else INx TVALID = 1: stay in BUSYx, next packet from the same source.
  - else: go to IDLE.
- A BUSYx input that drops TVALID mid-packet keeps the grant. The other source waits indefinitely; there is no timeout.
- Counters: PKT_COUNTx increments by 1 on every TLAST handshake from source x. It wraps from 2^CNT_WIDTH-1 to 0.
- Reset (asynchronous assert, any time, including mid-packet):
  - state IDLE, last_served = 2 (source 1 wins the first tie), both counters 0.
  - Consequently all TREADY = 0 and AXIS_OUT_TVALID/TDATA/TLAST = 0 while reset is high.
  - A partially forwarded packet is abandoned; its tail is not tracked.

## Timing
- Datapath is combinational through the mux in BUSYx: zero-cycle data latency, no buffering.
- Arbitration latency from IDLE: first beat can transfer one cycle after TVALID is sampled high.
- Packet-to-packet switching within BUSY1/BUSY2: no bubble cycle.
- TREADY of a granted input depends combinationally on AXIS_OUT_TREADY. No combinational path from any TVALID to any TREADY.
- Counters update on the same edge as the TLAST handshake and are visible the next cycle.

## Test plan
- Single source: IN1 sends 3-beat packet A1..A3, OUT_TREADY = 1 → OUT carries A1,A2,A3 on consecutive cycles after a 1-cycle IDLE; PKT_COUNT1 = 1, PKT_COUNT2 = 0.
- Tie after reset: both inputs valid with 2-beat packets → IN1 packet forwarded first, then IN2 with no bubble cycle; IN2_TREADY = 0 throughout the IN1 packet.
- Round robin: both sources stream 4 packets each continuously → output packet sources alternate 1,2,1,2,...; both counters end at 4.
- Backpressure and gaps: OUT_TREADY toggles every cycle and IN2 deasserts TVALID mid-packet while IN1 is valid → no beat lost or duplicated; IN1 is not granted until IN2's TLAST handshake.
- Reset mid-packet: assert reset during beat 2 of a 4-beat IN1 packet → all outputs 0 immediately (asynchronously); after release, a fresh IN2 packet is forwarded correctly and counters restart at 0.
- Counter wrap (CNT_WIDTH = 4): 17 IN1 packets → PKT_COUNT1 reads 1.
